// File: rtl/display_rx_if.sv
// Serial bus of the 4-chip alphanumeric LED display.
// The master drives the bus and the receiver/monitor samples it through the slave modport.
interface display_rx_if;
  logic disp_clock;
  logic disp_data_out;
  logic disp_rs;
  logic disp_ce_b;
  logic disp_reset_b;

  modport master (
    output disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b
  );
  modport slave (
    input disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b
  );
endinterface

// File: rtl/display_rx.sv
// Oversampling receiver for the LED display bus; rebuilds the dot register and control word.
// Optional latched-frame counter enabled by defining DISPLAY_RX_FRAME_COUNT_EN.
module display_rx #(
  parameter int DOT_BITS    = 640,
  parameter int CTRL_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock_27mhz,
  input  logic                 reset,
  display_rx_if.slave          bus,
  output logic [DOT_BITS-1:0]  dots_out,
  output logic [CTRL_BITS-1:0] control_out,
  output logic                 frame_strobe,
  output logic                 ctrl_strobe,
  output logic                 frame_error,
  output logic                 in_reset,
  output logic [15:0]          frame_count
);
  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] DOT_LEN  = CNT_W'(DOT_BITS);
  localparam logic [CNT_W-1:0] CTRL_LEN = CNT_W'(CTRL_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  logic [SYNC_STAGES-1:0] clk_sq, data_sq, rs_sq, ce_sq, rstb_sq;
  logic                   clk_prev_q, ce_prev_q;

  // Synchroniser chains start at the idle bus levels so release from reset looks quiet.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      clk_sq     <= '0;
      data_sq    <= '0;
      rs_sq      <= '0;
      ce_sq      <= '1;
      rstb_sq    <= '1;
      clk_prev_q <= 1'b0;
      ce_prev_q  <= 1'b1;
    end else begin
      clk_sq     <= {clk_sq[SYNC_STAGES-2:0], bus.disp_clock};
      data_sq    <= {data_sq[SYNC_STAGES-2:0], bus.disp_data_out};
      rs_sq      <= {rs_sq[SYNC_STAGES-2:0], bus.disp_rs};
      ce_sq      <= {ce_sq[SYNC_STAGES-2:0], bus.disp_ce_b};
      rstb_sq    <= {rstb_sq[SYNC_STAGES-2:0], bus.disp_reset_b};
      clk_prev_q <= clk_sq[SYNC_STAGES-1];
      ce_prev_q  <= ce_sq[SYNC_STAGES-1];
    end
  end

  logic clk_s, data_s, rs_s, ce_s, rstb_s;
  logic clk_rise, ce_fall, ce_rise, shift_en;

  assign clk_s    = clk_sq[SYNC_STAGES-1];
  assign data_s   = data_sq[SYNC_STAGES-1];
  assign rs_s     = rs_sq[SYNC_STAGES-1];
  assign ce_s     = ce_sq[SYNC_STAGES-1];
  assign rstb_s   = rstb_sq[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign ce_fall  = ~ce_s & ce_prev_q;
  assign ce_rise  = ce_s & ~ce_prev_q;
  // A clock edge coinciding with the enable rise still counts: gating uses the previous enable.
  assign shift_en = clk_rise & ~ce_prev_q;

  state_t               state_q;
  logic [DOT_BITS-1:0]  sr_q, sr_d, dots_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CTRL_BITS-1:0] ctrl_q;
  logic                 rs_l_q, frame_stb_q, ctrl_stb_q, err_q, in_reset_q;

  assign sr_d  = {sr_q[DOT_BITS-2:0], data_s};
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      dots_q      <= '0;
      ctrl_q      <= '0;
      rs_l_q      <= 1'b0;
      frame_stb_q <= 1'b0;
      ctrl_stb_q  <= 1'b0;
      err_q       <= 1'b0;
      in_reset_q  <= 1'b0;
    end else begin
      frame_stb_q <= 1'b0;
      ctrl_stb_q  <= 1'b0;
      err_q       <= 1'b0;
      in_reset_q  <= ~rstb_s;
      // Display reset wipes the control word but deliberately keeps the last dot frame.
      if (!rstb_s) begin
        ctrl_q  <= '0;
        cnt_q   <= '0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (ce_fall) begin
              cnt_q   <= '0;
              rs_l_q  <= rs_s;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (shift_en) begin
              sr_q  <= sr_d;
              cnt_q <= cnt_d;
            end
            if (ce_rise) state_q <= LATCH;
          end
          LATCH: begin
            state_q <= IDLE;
            if (!rs_l_q && cnt_q == DOT_LEN) begin
              dots_q      <= sr_q;
              frame_stb_q <= 1'b1;
            end else if (rs_l_q && cnt_q == CTRL_LEN) begin
              ctrl_q     <= sr_q[CTRL_BITS-1:0];
              ctrl_stb_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dots_out     = dots_q;
  assign control_out  = ctrl_q;
  assign frame_strobe = frame_stb_q;
  assign ctrl_strobe  = ctrl_stb_q;
  assign frame_error  = err_q;
  assign in_reset     = in_reset_q;

`ifdef DISPLAY_RX_FRAME_COUNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clock_27mhz) begin
    if (reset)            fcnt_q <= '0;
    else if (frame_stb_q) fcnt_q <= fcnt_q + 16'd1;
  end

  assign frame_count = fcnt_q;
`else
  assign frame_count = '0;
`endif
endmodule
